// File: rtl/instruction_fetch_unit_if.sv
// Bus between the fetch unit, the control FSM and the instruction memory read port.
// The fetch unit sits on the slave modport; the control/memory side uses master.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                         fetch_req;
  logic                         pc_write;
  logic [1:0]                   pc_src;
  logic signed [ADDR_WIDTH-1:0] branch_offset;
  logic [ADDR_WIDTH-1:0]        jump_target;
  logic [ADDR_WIDTH-1:0]        inst_address;
  logic [DATA_WIDTH-1:0]        read_data;
  logic [DATA_WIDTH-1:0]        instr;
  logic                         instr_valid;
  logic                         fetch_busy;
  logic [ADDR_WIDTH-1:0]        pc;
  logic [ADDR_WIDTH-1:0]        pc_plus1;
  logic                         addr_fault;

  modport master (
    output fetch_req, pc_write, pc_src, branch_offset, jump_target, read_data,
    input  inst_address, instr, instr_valid, fetch_busy, pc, pc_plus1, addr_fault
  );

  modport slave (
    input  fetch_req, pc_write, pc_src, branch_offset, jump_target, read_data,
    output inst_address, instr, instr_valid, fetch_busy, pc, pc_plus1, addr_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Multicycle-CPU instruction fetch: PC register, instruction register and a
// four-state fetch FSM that halts in FAULT when the PC leaves instruction memory.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  instruction_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET  = ADDR_WIDTH'(RESET_PC);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    valid_q, busy_q, fault_q;
  logic [ADDR_WIDTH-1:0]   pc_plus1;
  logic [ADDR_WIDTH-1:0]   pc_target;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} >= MEM_LIMIT;
  endfunction

  // Branch offset is two's complement; same-width add drops the carry.
  function automatic logic [ADDR_WIDTH-1:0] select_pc(
    input logic [1:0]                   src,
    input logic [ADDR_WIDTH-1:0]        cur,
    input logic [ADDR_WIDTH-1:0]        inc,
    input logic signed [ADDR_WIDTH-1:0] offset,
    input logic [ADDR_WIDTH-1:0]        target
  );
    logic [ADDR_WIDTH-1:0] res;
    case (src)
      2'b00:   res = inc;
      2'b01:   res = inc + $unsigned(offset);
      2'b10:   res = target;
      default: res = cur;
    endcase
    return res;
  endfunction

  assign pc_plus1  = pc_q + ADDR_WIDTH'(1);
  assign pc_target = select_pc(bus.pc_src, pc_q, pc_plus1, bus.branch_offset, bus.jump_target);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        if (bus.pc_write) pc_d = pc_target;
        // A PC written together with the request is range-checked on FETCH entry.
        if (bus.fetch_req) begin
          if (bus.pc_write || !out_of_range(pc_q)) state_d = FETCH;
          else                                     state_d = FAULT;
        end
      end
      FETCH: begin
        if (out_of_range(pc_q)) begin
          state_d = FAULT;
        end else begin
          instr_d = bus.read_data;
          pc_d    = bus.pc_write ? pc_target : pc_plus1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.pc_write) pc_d = pc_target;
        state_d = IDLE;
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d == FETCH);
      fault_q <= (state_d == FAULT);
    end
  end

  assign bus.inst_address = pc_q;
  assign bus.pc           = pc_q;
  assign bus.pc_plus1     = pc_plus1;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.fetch_busy   = busy_q;
  assign bus.addr_fault   = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word i holds value i.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  instruction_fetch_unit #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(256), .RESET_PC(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.read_data = 32'(bus.inst_address);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic jump(input logic [15:0] tgt);
    bus.pc_write = 1'b1; bus.pc_src = 2'b10; bus.jump_target = tgt;
    step();
    bus.pc_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.pc_write = 1'b0; bus.pc_src = 2'b00;
    bus.branch_offset = '0; bus.jump_target = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_valid", bus.instr_valid, 32'h0);
    chk("rst_busy", bus.fetch_busy, 32'h0);
    chk("rst_fault", bus.addr_fault, 32'h0);
    chk("rst_addr", bus.inst_address, 32'h0);
    chk("rst_pc_plus1", bus.pc_plus1, 32'h1);

    // Single fetch
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0;
    chk("f1_busy", bus.fetch_busy, 32'h1);
    chk("f1_valid_early", bus.instr_valid, 32'h0);
    step();
    chk("f1_instr", bus.instr, 32'h0);
    chk("f1_valid", bus.instr_valid, 32'h1);
    chk("f1_busy_done", bus.fetch_busy, 32'h0);
    chk("f1_pc", bus.pc, 32'h1);
    step();
    chk("f1_valid_drop", bus.instr_valid, 32'h0);

    // Back-to-back fetches with fetch_req held high
    rst = 1'b1; step(); rst = 1'b0;
    bus.fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("b2b_busy", bus.fetch_busy, 32'h1);
      chk("b2b_valid_fetch", bus.instr_valid, 32'h0);
      step();
      chk("b2b_instr", bus.instr, 32'(k));
      chk("b2b_valid", bus.instr_valid, 32'h1);
      step();
      chk("b2b_idle_valid", bus.instr_valid, 32'h0);
      chk("b2b_idle_busy", bus.fetch_busy, 32'h0);
    end
    bus.fetch_req = 1'b0;
    chk("b2b_pc", bus.pc, 32'h3);

    // Relative branch backwards, then fetch
    jump(16'h0005);
    chk("jmp5_pc", bus.pc, 32'h5);
    bus.pc_write = 1'b1; bus.pc_src = 2'b01; bus.branch_offset = 16'shFFFD;
    step(); bus.pc_write = 1'b0;
    chk("br_back_pc", bus.pc, 32'h3);
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0; step();
    chk("br_instr", bus.instr, 32'h3);
    chk("br_valid", bus.instr_valid, 32'h1);
    chk("br_pc_after", bus.pc, 32'h4);
    step();

    // Absolute jump to the last valid word
    jump(16'h00FF);
    chk("jmpff_pc", bus.pc, 32'hFF);
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0; step();
    chk("jff_instr", bus.instr, 32'hFF);
    chk("jff_pc", bus.pc, 32'h100);
    step();

    // Fetch at 0x0100 faults; pc_write is then ignored
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0;
    chk("flt_fault", bus.addr_fault, 32'h1);
    chk("flt_busy", bus.fetch_busy, 32'h0);
    chk("flt_valid", bus.instr_valid, 32'h0);
    jump(16'h0003);
    chk("flt_pc_frozen", bus.pc, 32'h100);
    chk("flt_instr_frozen", bus.instr, 32'hFF);
    step();
    chk("flt_sticky", bus.addr_fault, 32'h1);
    chk("flt_no_valid", bus.instr_valid, 32'h0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("flt_rst_pc", bus.pc, 32'h0);
    chk("flt_rst_fault", bus.addr_fault, 32'h0);

    // Jump during FETCH wins over the increment; IR takes the old-pc word
    jump(16'h0002);
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0;
    bus.pc_write = 1'b1; bus.pc_src = 2'b10; bus.jump_target = 16'h0007;
    step(); bus.pc_write = 1'b0;
    chk("fj_instr", bus.instr, 32'h2);
    chk("fj_pc", bus.pc, 32'h7);
    step();

    // Reset during FETCH abandons the fetch
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0;
    chk("rf_busy", bus.fetch_busy, 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rf_instr", bus.instr, 32'h0);
    chk("rf_valid", bus.instr_valid, 32'h0);
    chk("rf_pc", bus.pc, 32'h0);
    step();
    chk("rf_valid_after", bus.instr_valid, 32'h0);
    chk("rf_busy_after", bus.fetch_busy, 32'h0);

    // Wraparound arithmetic at the top of the address space
    jump(16'hFFFF);
    chk("wrap_plus1", bus.pc_plus1, 32'h0);
    bus.pc_write = 1'b1; bus.pc_src = 2'b01; bus.branch_offset = 16'sh0001;
    step(); bus.pc_write = 1'b0;
    chk("wrap_branch", bus.pc, 32'h1);
    bus.pc_write = 1'b1; bus.pc_src = 2'b00;
    step(); bus.pc_write = 1'b0;
    chk("seq_write", bus.pc, 32'h2);

    // pc_write with fetch_req to an out-of-range pc: FETCH then FAULT, IR untouched
    bus.pc_write = 1'b1; bus.pc_src = 2'b10; bus.jump_target = 16'h0200;
    bus.fetch_req = 1'b1; step();
    bus.pc_write = 1'b0; bus.fetch_req = 1'b0;
    chk("wf_busy", bus.fetch_busy, 32'h1);
    chk("wf_pc", bus.pc, 32'h200);
    step();
    chk("wf_fault", bus.addr_fault, 32'h1);
    chk("wf_instr", bus.instr, 32'h0);
    chk("wf_valid", bus.instr_valid, 32'h0);
    chk("wf_busy_off", bus.fetch_busy, 32'h0);
    rst = 1'b1; step(); rst = 1'b0;

    // Hold source during FETCH suppresses the increment
    jump(16'h0009);
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0;
    bus.pc_write = 1'b1; bus.pc_src = 2'b11;
    step(); bus.pc_write = 1'b0;
    chk("hold_instr", bus.instr, 32'h9);
    chk("hold_pc", bus.pc, 32'h9);
    step();

    // Fetch at 0xFFFF faults directly from IDLE
    jump(16'hFFFF);
    bus.fetch_req = 1'b1; step(); bus.fetch_req = 1'b0;
    chk("top_fault", bus.addr_fault, 32'h1);
    chk("top_busy", bus.fetch_busy, 32'h0);
    chk("top_pc", bus.pc, 32'hFFFF);
    chk("top_instr", bus.instr, 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction memory read port in the multicycle CPU.
- Holds the program counter and drives the memory's word address.
- Captures the returned 32-bit word into an instruction register when the control FSM requests a fetch.
- Applies sequential, relative-branch and absolute-jump PC updates.
- Flags out-of-range fetches so the core halts instead of executing garbage.

Parameters:
ADDR_WIDTH, 16, width of PC and inst_address (word address, one instruction per address)
DATA_WIDTH, 32, instruction width
MEM_DEPTH, 256, number of valid instruction words; addresses >= MEM_DEPTH are faults
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
fetch_req  in  1  control FSM requests one instruction fetch
pc_write  in  1  load new PC this cycle
pc_src  in  2  PC source when pc_write=1: 00 = pc+1, 01 = pc+1+branch_offset, 10 = jump_target, 11 = hold
branch_offset  in  ADDR_WIDTH  signed word offset, two's complement
jump_target  in  ADDR_WIDTH  absolute word address
inst_address  out  ADDR_WIDTH  address to instruction memory; always equals pc
read_data  in  DATA_WIDTH  combinational read data from instruction memory
instr  out  DATA_WIDTH  instruction register
instr_valid  out  1  one-cycle pulse: instr just updated
fetch_busy  out  1  fetch in progress (state FETCH)
pc  out  ADDR_WIDTH  current program counter
pc_plus1  out  ADDR_WIDTH  pc+1, modulo 2^ADDR_WIDTH, combinational
addr_fault  out  1  sticky: fetch attempted at pc >= MEM_DEPTH

Behaviour:
- Reset (any state, synchronous): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, fetch_busy=0, addr_fault=0. An in-flight fetch is abandoned; no partial IR update.
- Memory read is combinational. inst_address = pc at all times; the IR samples read_data at the clock edge.
- States:
  - IDLE: fetch_req=1 and pc < MEM_DEPTH -> FETCH. fetch_req=1 and pc >= MEM_DEPTH -> FAULT.
  - FETCH (fetch_busy=1): at the edge, instr <= read_data, pc <= pc+1 (unless pc_write), -> DONE.
  - DONE: instr_valid=1 for exactly this cycle -> IDLE unconditionally.
  - FAULT: addr_fault=1, instr frozen, instr_valid=0, pc frozen, pc_write ignored; exits only on rst.
- Fetch latency: fetch_req sampled at edge N; the IR loads at edge N+1; instr_valid is high in the cycle following edge N+1. The FSM accepts at most one fetch per 3 cycles.
- fetch_req in FETCH or DONE is ignored (not queued).
- pc_write is accepted in IDLE, FETCH and DONE.
  - In FETCH, pc_write has priority over the auto-increment, but the IR still loads the word at the old pc.
  - pc_write with fetch_req in IDLE: the PC updates at that edge and the fetch uses the new pc. The fault check uses the new pc in FETCH entry: if the new pc >= MEM_DEPTH, FETCH -> FAULT at the next edge without loading the IR.
- Arithmetic: all PC math is modulo 2^ADDR_WIDTH.
  - Branch target = pc_plus1 + branch_offset (full-width signed add, carry dropped).
  - 0xFFFF+1 = 0x0000.
  - Out-of-range targets are legal to load; they fault only when fetched.
- pc_src=11 with pc_write=1 leaves pc unchanged; in FETCH it also suppresses the increment.
- Outputs are registered except inst_address and pc_plus1.

Test Plan:
Memory preloaded so word i holds value i.
- Reset, then fetch_req pulse -> fetch_busy high 1 cycle; instr=0x00000000, instr_valid pulse 2 cycles after request; pc=1.
- Three back-to-back fetches (fetch_req held high) -> instr 0,1,2 across three DONE pulses, 3 cycles apart; pc=3; requests during FETCH/DONE ignored.
- pc=5, pc_write pc_src=01 branch_offset=0xFFFD -> pc=3; fetch -> instr=3. With pc_src=10 jump_target=0x00FF, fetch -> instr=0xFF, pc=0x0100.
- Fetch with pc=0x0100 -> FAULT, addr_fault=1, instr stays 0xFF, no instr_valid. A further pc_write is ignored; rst clears to pc=0, addr_fault=0.
- pc_write pc_src=10 target=7 asserted during FETCH at pc=2 -> instr=2, pc=7 (not 3). rst asserted in FETCH -> instr=0, instr_valid never pulses.
- Load jump_target=0xFFFF, branch_offset=1 -> pc_plus1 wraps to 0x0000; branch target=0x0001. Fetch at 0xFFFF faults.
